proc_hex_display: RTL and testbench

//  Downstream consumer of the TinyRV1 processor's I/O outputs. Selects one of
//  out0/out1/out2/trace_data and drives a time-multiplexed, active-low

---
 rtl/proc_hex_display.sv | 134 +++++++++++++
 tb/tb_proc_hex_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/proc_hex_display.sv
// Hex readout of a TinyRV1 I/O word on a multiplexed common-anode 7-segment display.
// Each scan shows one snapshot of the selected source; digit 0's point flags a new value.
module proc_hex_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           out0,
    input  logic [31:0]           out1,
    input  logic [31:0]           out2,
    input  logic [31:0]           trace_data,
    input  logic [1:0]            disp_sel,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    logic [PRESC_W-1:0]    presc_r;
    logic [IDX_W-1:0]      idx_r;
    logic [31:0]           snap_r;
    logic [31:0]           prev_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;
    logic                  dp_r;

    logic                  tick_s;
    logic                  wrap_s;
    logic                  chg_s;
    logic                  nz_s;
    logic                  blank_s;
    logic                  dp_n_s;
    logic [IDX_W-1:0]      idx_n_s;
    logic [31:0]           src_s;
    logic [31:0]           s_s;
    logic [3:0]            nib_s;
    logic [6:0]            seg_n_s;
    logic [NUM_DIGITS-1:0] an_n_s;

    // Source select, sampled every cycle but only captured at a wrap to digit 0
    always_comb begin
        case (disp_sel)
            2'd0:    src_s = out0;
            2'd1:    src_s = out1;
            2'd2:    src_s = out2;
            default: src_s = trace_data;
        endcase
    end

    // Next digit and the post-update digit image; the change flag is carried as snap != prev
    always_comb begin
        tick_s = (presc_r == PRESC_LAST);
        if (idx_r == IDX_LAST) begin
            idx_n_s = '0;
        end else begin
            idx_n_s = idx_r + IDX_W'(1);
        end
        wrap_s = (idx_n_s == '0);
        if (wrap_s) begin
            s_s   = src_s;
            chg_s = (src_s != snap_r);
        end else begin
            s_s   = snap_r;
            chg_s = (snap_r != prev_r);
        end
        nib_s = s_s[{idx_n_s, 2'b00} +: 4];
        nz_s  = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            nz_s = nz_s | ((IDX_W'(j) >= idx_n_s) && (s_s[4*j +: 4] != 4'd0));
        end
        blank_s = (BLANK_LZ != 0) && (idx_n_s != '0) && !nz_s;
        seg_n_s = blank_s ? 7'h7F : hex7(nib_s);
        an_n_s  = ~(NUM_DIGITS'(1) << idx_n_s);
        dp_n_s  = ~(chg_s && wrap_s);
    end

    // Prescaler, scan index, snapshot and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= IDX_LAST;
            snap_r  <= 32'd0;
            prev_r  <= 32'd0;
            an_r    <= '1;
            seg_r   <= 7'h7F;
            dp_r    <= 1'b1;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= idx_n_s;
            if (wrap_s) begin
                snap_r <= src_s;
                prev_r <= snap_r;
            end
            an_r  <= an_n_s;
            seg_r <= seg_n_s;
            dp_r  <= dp_n_s;
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_proc_hex_display.sv
// Randomised and directed bench for proc_hex_display against a scan-level reference model,
// with one instance blanking leading zeros and one not.
module tb_proc_hex_display;

    localparam int ND = 8;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] out0 = 32'd0, out1 = 32'd0, out2 = 32'd0, trace_data = 32'd0;
    logic [1:0]  disp_sel = 2'd0;
    logic [7:0]  an_b, an_n;
    logic [6:0]  seg_b, seg_n;
    logic        dp_b, dp_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    proc_hex_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .out0(out0), .out1(out1), .out2(out2),
        .trace_data(trace_data), .disp_sel(disp_sel), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    proc_hex_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_n (
        .clk(clk), .rst(rst), .out0(out0), .out1(out1), .out2(out2),
        .trace_data(trace_data), .disp_sel(disp_sel), .an(an_n), .seg(seg_n), .dp(dp_n)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] s, input int d, input bit blz);
        logic [31:0] up;
        up = s >> (4 * d);
        if (blz && d > 0 && up == 32'd0) return 7'h7F;
        return hex_tab[up[3:0]];
    endfunction

    function automatic logic [31:0] sel_val();
        case (disp_sel)
            2'd0:    return out0;
            2'd1:    return out1;
            2'd2:    return out2;
            default: return trace_data;
        endcase
    endfunction

    // Reference model: cycles since the last tick, current digit, shown value, change flag
    int          m_cnt = 0;
    int          m_dig = ND - 1;
    logic [31:0] m_snap = 32'd0;
    bit          m_chg = 1'b0;
    bit          model_ok = 1'b0;
    logic [7:0]  e_an;
    logic [6:0]  e_seg_b, e_seg_n;
    logic        e_dp;

    always @(posedge clk) begin
        logic [31:0] v;
        if (rst) begin
            m_cnt = 0; m_dig = ND - 1; m_snap = 32'd0; m_chg = 1'b0;
            e_an = 8'hFF; e_seg_b = 7'h7F; e_seg_n = 7'h7F; e_dp = 1'b1;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_cnt++;
            if (m_cnt == RD) begin
                m_cnt = 0;
                m_dig = (m_dig + 1) % ND;
                if (m_dig == 0) begin
                    v = sel_val();
                    m_chg = (v != m_snap);
                    m_snap = v;
                end
                e_an    = 8'hFF ^ (8'd1 << m_dig);
                e_seg_b = exp_seg(m_snap, m_dig, 1'b1);
                e_seg_n = exp_seg(m_snap, m_dig, 1'b0);
                e_dp    = !(m_chg && m_dig == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check_val("an_blz",  an_b,  e_an);
            check_val("seg_blz", seg_b, e_seg_b);
            check_val("dp_blz",  dp_b,  e_dp);
            check_val("an_nob",  an_n,  e_an);
            check_val("seg_nob", seg_n, e_seg_n);
            check_val("dp_nob",  dp_n,  e_dp);
        end
    end

    task automatic wait_digit(input int d);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!rst && m_dig == d && m_cnt == 0) return;
        end
        check_val("wait_digit_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_scan(input string tag, input logic [55:0] codes);
        wait_digit(0);
        for (int d = 0; d < ND; d++) begin
            check_val(tag, seg_n, codes[7*d +: 7]);
            repeat (RD) @(negedge clk);
        end
    endtask

    initial begin
        bit found;
        repeat (2) @(negedge clk);

        // first tick shows digit 0 with the change point lit
        out0 = 32'h1234ABCD; disp_sel = 2'd0; rst = 1'b0;
        repeat (RD) @(negedge clk);
        check_val("t1_an0",  an_b,  8'hFE);
        check_val("t1_seg0", seg_b, 7'h21);
        check_val("t1_dp0",  dp_b,  1'b0);
        repeat (RD) @(negedge clk);
        check_val("t1_an1",  an_b,  8'hFD);
        check_val("t1_seg1", seg_b, 7'h46);
        repeat (RD * 6) @(negedge clk);
        check_val("t1_an7",  an_b,  8'h7F);
        check_val("t1_seg7", seg_b, 7'h79);
        repeat (RD) @(negedge clk);
        check_val("t1_dp_rescan", dp_b, 1'b1);

        // small value: leading zeros blanked only on the blanking instance
        out1 = 32'h0000_0005; disp_sel = 2'd1;
        wait_digit(0);
        check_val("t2_seg0", seg_b, 7'h12);
        repeat (RD) @(negedge clk);
        check_val("t2_seg1_blz", seg_b, 7'h7F);
        check_val("t2_seg1_nob", seg_n, 7'h40);
        check_val("t2_an1", an_b, 8'hFD);

        // mid-scan source switch waits for the next wrap
        wait_digit(3);
        disp_sel = 2'd2; out2 = 32'hFFFF_FFFF;
        repeat (RD) @(negedge clk);
        check_val("t3_old_blz", seg_b, 7'h7F);
        check_val("t3_old_nob", seg_n, 7'h40);
        wait_digit(0);
        check_val("t3_seg0", seg_b, 7'h0E);
        check_val("t3_dp0", dp_b, 1'b0);
        repeat (RD * 7) @(negedge clk);
        check_val("t3_seg7", seg_b, 7'h0E);

        // unchanged value clears the point; a trace change sets it for one scan
        wait_digit(0);
        check_val("t4_same_dp", dp_b, 1'b1);
        disp_sel = 2'd3; trace_data = 32'hCAFE_0000;
        wait_digit(0);
        check_val("t4_chg_dp", dp_b, 1'b0);
        check_val("t4_seg0", seg_b, 7'h40);
        wait_digit(0);
        check_val("t4_hold_dp", dp_b, 1'b1);

        // reset mid-scan at presc=2, idx=5
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (m_dig == 5 && m_cnt == 2) found = 1'b1;
        end
        check_val("t5_found", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_an_rst",  an_b,  8'hFF);
        check_val("t5_seg_rst", seg_b, 7'h7F);
        check_val("t5_dp_rst",  dp_b,  1'b1);
        rst = 1'b0;
        repeat (RD - 1) @(negedge clk);
        check_val("t5_an_pre", an_b, 8'hFF);
        @(negedge clk);
        check_val("t5_an_first", an_b, 8'hFE);

        // every nibble code
        out0 = 32'h0123_4567; disp_sel = 2'd0;
        wait_digit(0);
        check_scan("t6_lo", {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78});
        out0 = 32'h89AB_CDEF;
        wait_digit(0);
        check_scan("t6_hi", {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});

        // random sources, selects, hold times and occasional resets
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            out0       = $urandom >> $urandom_range(0, 31);
            out1       = $urandom >> $urandom_range(0, 31);
            out2       = $urandom >> $urandom_range(0, 31);
            trace_data = ($urandom_range(0, 3) == 0) ? trace_data : ($urandom >> $urandom_range(0, 31));
            disp_sel   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        repeat (RD * ND) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
